reg_bank_store: RTL

//   Register bank and write-back sequencer directly downstream of control_unit.
//   - Provides operand read ports to the ALU.
//   - Executes the enable pulses issued by control_unit in EXECUTE: write, clear, display read.
//   - Returns store_done, which releases control_unit from STORE back to IDLE.
//   - Display reads hand a value to the LCD driver via a valid/ready handshake.

---
 rtl/reg_bank_store_if.sv | 36 +++
 rtl/reg_bank_store.sv | 132 +++++++++++++
 2 files changed

// File: rtl/reg_bank_store_if.sv
// Bundles the command, operand, display and completion signals exchanged
// between the register bank and its neighbours (control_unit, ALU, LCD driver).
interface reg_bank_store_if #(
  parameter int DATA_W = 16
);
  logic [3:0]        DEST;
  logic [3:0]        SRC1;
  logic [3:0]        SRC2;
  logic              IMM_SIGN;
  logic [5:0]        IMM_MAGNETUDE;
  logic              alu_enable;
  logic              write_enable;
  logic              read_enable;
  logic              clear_mem;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              disp_ready;
  logic              store_done;

  modport master (
    output DEST, SRC1, SRC2, IMM_SIGN, IMM_MAGNETUDE,
    output alu_enable, write_enable, read_enable, clear_mem,
    output alu_result, disp_ready,
    input  op_a, op_b, disp_data, disp_valid, store_done
  );

  modport slave (
    input  DEST, SRC1, SRC2, IMM_SIGN, IMM_MAGNETUDE,
    input  alu_enable, write_enable, read_enable, clear_mem,
    input  alu_result, disp_ready,
    output op_a, op_b, disp_data, disp_valid, store_done
  );
endinterface

// File: rtl/reg_bank_store.sv
// Register bank plus write-back sequencer: executes LOAD / ALU write / clear-all /
// display commands one at a time and pulses store_done when each completes.
module reg_bank_store #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 16,
  parameter int ALU_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst,
  reg_bank_store_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ALU,
    CLEAR,
    DISP,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [3:0]        dest_q, dest_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              disp_valid_q, disp_valid_d;
  logic [DATA_W-1:0] load_mag;
  logic [DATA_W-1:0] load_val;

  // Sign/magnitude immediate to two's complement; a negative zero collapses to 0.
  assign load_mag = {{(DATA_W-6){1'b0}}, bus.IMM_MAGNETUDE};
  assign load_val = bus.IMM_SIGN ? (~load_mag + {{(DATA_W-1){1'b0}}, 1'b1}) : load_mag;

  assign bus.op_a       = regs_q[bus.SRC1];
  assign bus.op_b       = regs_q[bus.SRC2];
  assign bus.disp_data  = disp_data_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.store_done = (state_q == DONE);

  always_comb begin
    state_d      = state_q;
    regs_d       = regs_q;
    dest_d       = dest_q;
    cnt_d        = cnt_q;
    clr_idx_d    = clr_idx_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = disp_valid_q;

    case (state_q)
      IDLE: begin
        if (bus.clear_mem) begin
          clr_idx_d = '0;
          state_d   = CLEAR;
        end else if (bus.write_enable) begin
          dest_d = bus.DEST;
          if (bus.alu_enable) begin
            cnt_d   = CNT_W'(ALU_LATENCY - 1);
            state_d = WAIT_ALU;
          end else begin
            regs_d[bus.DEST] = load_val;
            state_d          = DONE;
          end
        end else if (bus.read_enable) begin
          disp_data_d  = regs_q[bus.SRC1];
          disp_valid_d = 1'b1;
          state_d      = DISP;
        end
      end

      WAIT_ALU: begin
        if (cnt_q == '0) begin
          regs_d[dest_q] = bus.alu_result;
          state_d        = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      // One register per cycle, so readers see a partially cleared bank meanwhile.
      CLEAR: begin
        regs_d[clr_idx_q] = '0;
        clr_idx_d         = clr_idx_q + IDX_W'(1);
        if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
          state_d = DONE;
        end
      end

      DISP: begin
        if (bus.disp_ready) begin
          disp_valid_d = 1'b0;
          state_d      = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      dest_q       <= '0;
      cnt_q        <= '0;
      clr_idx_q    <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      dest_q       <= dest_d;
      cnt_q        <= cnt_d;
      clr_idx_q    <= clr_idx_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      regs_q       <= regs_d;
    end
  end

endmodule
